// File: rtl/node_dispatch_pkg.sv
// Shared types, default sizing and the round-robin helper for the node_dispatch stage.
package node_dispatch_pkg;

    localparam int DEF_NUM_CHILDREN = 5;
    localparam int DEF_MAX_OUT      = 4;
    localparam int MAX_FANOUT       = 16;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // First set bit of elig, scanning upward from start and wrapping at n.
    function automatic pick_t rr_first(input logic [MAX_FANOUT-1:0] elig,
                                       input int n, input int start);
        pick_t res;
        int    j;
        res = '0;
        for (int i = 0; i < MAX_FANOUT; i++) begin
            if (i < n) begin
                j = start + i;
                if (j >= n) j = j - n;
                if (!res.found && elig[j]) begin
                    res.found = 1'b1;
                    res.idx   = 4'(j);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/node_dispatch_if.sv
// Parent-side and child-side signal bundle of node_dispatch; master drives tokens, slave dispatches.
interface node_dispatch_if
    import node_dispatch_pkg::*;
#(
    parameter int NUM_CHILDREN = DEF_NUM_CHILDREN,
    parameter int DATA_W       = 16
);
    logic                    up_valid;
    logic                    up_ready;
    logic [DATA_W-1:0]       up_data;
    logic [NUM_CHILDREN-1:0] dn_valid;
    logic [NUM_CHILDREN-1:0] dn_ready;
    logic [DATA_W-1:0]       dn_data;
    logic [NUM_CHILDREN-1:0] cpl;
    logic [2:0]              cpl_cnt;
    logic                    flush;
    logic                    flush_done;
    logic                    cpl_err;

    modport master (
        output up_valid, up_data, dn_ready, cpl, flush,
        input  up_ready, dn_valid, dn_data, cpl_cnt, flush_done, cpl_err
    );

    modport slave (
        input  up_valid, up_data, dn_ready, cpl, flush,
        output up_ready, dn_valid, dn_data, cpl_cnt, flush_done, cpl_err
    );
endinterface

// File: rtl/node_dispatch_fifo.sv
// Two-entry input buffer; head is valid whenever empty is low.
module node_dispatch_fifo #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is left unreset on purpose; count alone says which entries hold data.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);

endmodule

// File: rtl/node_dispatch.sv
// Round-robin, credit-limited dispatch of parent tokens to child instances, with drain/flush control.
module node_dispatch
    import node_dispatch_pkg::*;
#(
    parameter int NUM_CHILDREN = DEF_NUM_CHILDREN,
    parameter int DATA_W       = 16,
    parameter int MAX_OUT      = DEF_MAX_OUT
) (
    input logic            clk,
    input logic            rst_n,
    node_dispatch_if.slave bus
);
    localparam logic [1:0] S_RUN   = ST_RUN;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic                    full, empty;
    logic [DATA_W-1:0]       head;
    logic [1:0]              state_q, state_d;
    logic [3:0]              rr_q, lock_idx_q, tgt;
    logic                    lock_q;
    logic [2:0]              credit_q [NUM_CHILDREN];
    logic [2:0]              cpl_cnt_q;
    logic                    cpl_err_q;
    logic [MAX_FANOUT-1:0]   elig;
    logic [NUM_CHILDREN-1:0] busy, cpl_ok, dn_vec, issue;
    pick_t                   pick;
    logic                    sel_valid, hs, push, up_ready;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        elig   = '0;
        busy   = '0;
        cpl_ok = '0;
        for (int k = 0; k < NUM_CHILDREN; k++) begin
            elig[k]   = credit_q[k] < 3'(MAX_OUT);
            busy[k]   = credit_q[k] != 3'd0;
            cpl_ok[k] = bus.cpl[k] && busy[k];
        end
    end

    // A held dispatch keeps its target even if an earlier child frees a credit meanwhile.
    assign pick      = rr_first(elig, NUM_CHILDREN, int'(rr_q));
    assign tgt       = lock_q ? lock_idx_q : pick.idx;
    assign sel_valid = !empty && (lock_q || pick.found);
    assign dn_vec    = NUM_CHILDREN'(1) << tgt;
    assign hs        = sel_valid && |(bus.dn_ready & dn_vec);
    assign issue     = hs ? dn_vec : '0;
    assign up_ready  = !full && (state_q == S_RUN);
    assign push      = bus.up_valid && up_ready;

    node_dispatch_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (bus.up_data),
        .pop   (hs),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (bus.flush) state_d = S_DRAIN;
            S_DRAIN: if (empty && !(|busy)) state_d = S_DONE;
            S_DONE:  state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // NOTE: all state below updates with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            cpl_cnt_q  <= '0;
            cpl_err_q  <= 1'b0;
            for (int k = 0; k < NUM_CHILDREN; k++) credit_q[k] <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= sel_valid && !hs;
            if (sel_valid) lock_idx_q <= tgt;
            if (hs) rr_q <= (tgt == 4'(NUM_CHILDREN - 1)) ? 4'd0 : tgt + 4'd1;
            cpl_cnt_q <= 3'($countones(cpl_ok));
            if (|(bus.cpl & ~busy)) cpl_err_q <= 1'b1;
            for (int k = 0; k < NUM_CHILDREN; k++) begin
                if (issue[k] && !cpl_ok[k])      credit_q[k] <= credit_q[k] + 3'd1;
                else if (cpl_ok[k] && !issue[k]) credit_q[k] <= credit_q[k] - 3'd1;
            end
        end
    end

    assign bus.up_ready   = up_ready;
    assign bus.dn_valid   = sel_valid ? dn_vec : '0;
    assign bus.dn_data    = sel_valid ? head : '0;
    assign bus.cpl_cnt    = cpl_cnt_q;
    assign bus.flush_done = (state_q == S_DONE);
    assign bus.cpl_err    = cpl_err_q;

endmodule
